fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one width-converting result FIFO (64-bit write side, FWFT read side) between NREQ hash-core requesters in the miner datapath. Each requester presents a packet of up to BURST 64-bit words with valid/ready/last; the arbiter grants one requester at a time and forwards its words to the FIFO write port. Packets are never interleaved in the FIFO. The arbiter throttles on FIFO full.

---
 rtl/fifo_wr_arbiter.sv | 119 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one result FIFO write port between NREQ hash-core requesters.
// Optional stall statistics counter is compiled in when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned DWIDTH = 64,
   parameter int unsigned BURST  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0]          req_last,
   input  logic [NREQ*DWIDTH-1:0]   req_data,
   output logic [NREQ-1:0]          req_ready,
   output logic                     fifo_wr_en,
   output logic [DWIDTH-1:0]        fifo_din,
   input  logic                     fifo_full,
   output logic [NREQ-1:0]          grant,
   output logic                     busy,
   output logic [31:0]              stall_cnt
);

   localparam int unsigned OW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned OW1 = OW + 1;
   localparam int unsigned CW  = $clog2(BURST + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state;
   logic [OW-1:0]   last_owner;
   logic [OW-1:0]   owner;
   logic [CW-1:0]   word_cnt;

   logic            pick_valid;
   logic [OW-1:0]   pick_idx;
   logic [OW1-1:0]  cand;
   logic            owner_valid;
   logic            owner_last;
   logic            accept;
   logic            rel;

   // Round-robin search starting one past the previous owner
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = {1'b0, last_owner} + OW1'(k + 1);
         if (cand >= OW1'(NREQ)) cand = cand - OW1'(NREQ);
         if (!pick_valid && req_valid[cand[OW-1:0]]) begin
            pick_valid = 1'b1;
            pick_idx   = cand[OW-1:0];
         end
      end
   end

   // Write path is combinational from the registered grant so full throttles in-cycle
   always_comb begin
      fifo_din = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant[i]) fifo_din = fifo_din | req_data[i*DWIDTH +: DWIDTH];
      end
   end

   assign owner_valid = |(grant & req_valid);
   assign owner_last  = |(grant & req_last);
   assign req_ready   = grant & {NREQ{~fifo_full}};
   assign fifo_wr_en  = owner_valid & ~fifo_full;
   assign accept      = fifo_wr_en;
   assign rel         = accept & (owner_last | (word_cnt == CW'(BURST - 1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         grant      <= '0;
         busy       <= 1'b0;
         owner      <= '0;
         last_owner <= OW'(NREQ - 1);
         word_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  state    <= GRANT;
                  grant    <= NREQ'(1) << pick_idx;
                  busy     <= 1'b1;
                  owner    <= pick_idx;
                  word_cnt <= '0;
               end
            end
            GRANT: begin
               // A packet longer than BURST is cut here; the rest re-arbitrates
               if (rel) begin
                  state      <= IDLE;
                  grant      <= '0;
                  busy       <= 1'b0;
                  last_owner <= owner;
                  word_cnt   <= '0;
               end else if (accept) begin
                  word_cnt <= word_cnt + CW'(1);
               end
            end
         endcase
      end
   end

`ifdef FIFO_ARB_STATS_EN
   // Saturating count of cycles the owner had data but the FIFO was full
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (owner_valid && fifo_full && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`else
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Table-driven bench for fifo_wr_arbiter with a scoreboard of expected FIFO writes.
module tb_fifo_wr_arbiter;

   localparam int unsigned NREQ   = 4;
   localparam int unsigned DWIDTH = 64;
   localparam int unsigned BURST  = 4;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_last;
   logic [NREQ*DWIDTH-1:0] req_data;
   logic [NREQ-1:0]        req_ready;
   logic                   fifo_wr_en;
   logic [DWIDTH-1:0]      fifo_din;
   logic                   fifo_full;
   logic [NREQ-1:0]        grant;
   logic                   busy;
   logic [31:0]            stall_cnt;

   fifo_wr_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH), .BURST(BURST)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_last   (req_last),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .fifo_wr_en (fifo_wr_en),
      .fifo_din   (fifo_din),
      .fifo_full  (fifo_full),
      .grant      (grant),
      .busy       (busy),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rst;
      logic        clr;
      logic [3:0]  valid;
      logic [3:0]  last;
      logic        full;
      logic [3:0]  g;
      logic        w;
      logic [63:0] din;
   } vec_t;

   vec_t        vecs[$];
   logic [63:0] sb[$];
   int unsigned seq[NREQ];
   logic [3:0]  hs;
   int          n_vec;
   int          n_err;
   logic [31:0] stall_model;

   function automatic logic [63:0] mk(int unsigned tag, int unsigned idx);
      return {32'(tag), 32'(idx)};
   endfunction

   function automatic void add(logic rst, logic clr, logic [3:0] valid, logic [3:0] last,
                               logic full, logic [3:0] g, logic w, logic [63:0] din);
      vec_t v;
      v.rst = rst; v.clr = clr; v.valid = valid; v.last = last;
      v.full = full; v.g = g; v.w = w; v.din = din;
      vecs.push_back(v);
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_seq();
      for (int i = 0; i < NREQ; i++) seq[i] = 0;
   endtask

   task automatic drive(logic [3:0] valid, logic [3:0] last, logic full);
      req_valid = valid;
      req_last  = last;
      fifo_full = full;
      for (int i = 0; i < NREQ; i++) req_data[i*DWIDTH +: DWIDTH] = mk(i, seq[i]);
   endtask

   // Advance each requester's word index after a completed handshake
   task automatic step_edge();
      @(posedge clk);
      for (int i = 0; i < NREQ; i++) if (hs[i]) seq[i]++;
      hs = '0;
      #1;
   endtask

   task automatic apply(vec_t v);
      step_edge();
      if (v.rst) begin
         rst_n = 1'b0;
         #2;
         rst_n = 1'b1;
         clear_seq();
         stall_model = '0;
      end
      if (v.clr) clear_seq();
      drive(v.valid, v.last, v.full);
      if (v.w) sb.push_back(v.din);
      @(negedge clk);
      check("grant", 64'(grant), 64'(v.g));
      check("busy", 64'(busy), 64'(v.g != 4'b0000));
      check("wr_en", 64'(fifo_wr_en), 64'(v.w));
      check("req_ready", 64'(req_ready), 64'(v.g & ~{4{v.full}}));
      if (fifo_wr_en) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: got %h expected no write at %0t", fifo_din, $time);
         end else begin
            check("fifo_din", fifo_din, sb.pop_front());
         end
      end
      if (v.g == 4'b0000) check("din_idle", fifo_din, 64'd0);
      check("stall_cnt", 64'(stall_cnt), 64'(stall_model));
`ifdef FIFO_ARB_STATS_EN
      if (((v.g & v.valid) != 4'b0000) && v.full) stall_model++;
`endif
      hs = req_ready & req_valid;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      hs = '0;
      stall_model = '0;
      clear_seq();
      rst_n = 1'b0;
      drive(4'b0000, 4'b0000, 1'b0);

      // Single requester: req 2 sends A,B,C
      add(0,1,4'b0100,4'b0000,0,4'b0000,0,64'd0);
      add(0,0,4'b0100,4'b0000,0,4'b0100,1,mk(2,0));
      add(0,0,4'b0100,4'b0000,0,4'b0100,1,mk(2,1));
      add(0,0,4'b0100,4'b0100,0,4'b0100,1,mk(2,2));
      add(0,0,4'b0000,4'b0000,0,4'b0000,0,64'd0);
      // Round-robin over 1-word packets from reset
      add(1,0,4'b1111,4'b1111,0,4'b0000,0,64'd0);
      add(0,0,4'b1111,4'b1111,0,4'b0001,1,mk(0,0));
      add(0,0,4'b1111,4'b1111,0,4'b0000,0,64'd0);
      add(0,0,4'b1111,4'b1111,0,4'b0010,1,mk(1,0));
      add(0,0,4'b1111,4'b1111,0,4'b0000,0,64'd0);
      add(0,0,4'b1111,4'b1111,0,4'b0100,1,mk(2,0));
      add(0,0,4'b1111,4'b1111,0,4'b0000,0,64'd0);
      add(0,0,4'b1111,4'b1111,0,4'b1000,1,mk(3,0));
      add(0,0,4'b1111,4'b1111,0,4'b0000,0,64'd0);
      add(0,0,4'b1111,4'b1111,0,4'b0001,1,mk(0,1));
      add(0,0,4'b0000,4'b0000,0,4'b0000,0,64'd0);
      // BURST split of a 6-word packet
      add(0,1,4'b0010,4'b0000,0,4'b0000,0,64'd0);
      for (int k = 0; k < 4; k++) add(0,0,4'b0010,4'b0000,0,4'b0010,1,mk(1,k));
      add(0,0,4'b0010,4'b0000,0,4'b0000,0,64'd0);
      add(0,0,4'b0010,4'b0000,0,4'b0010,1,mk(1,4));
      add(0,0,4'b0010,4'b0010,0,4'b0010,1,mk(1,5));
      add(0,0,4'b0000,4'b0000,0,4'b0000,0,64'd0);
      // Full stall for 5 cycles on the second word
      add(1,0,4'b1000,4'b0000,0,4'b0000,0,64'd0);
      add(0,0,4'b1000,4'b0000,0,4'b1000,1,mk(3,0));
      for (int k = 0; k < 5; k++) add(0,0,4'b1000,4'b0000,1,4'b1000,0,64'd0);
      add(0,0,4'b1000,4'b0000,0,4'b1000,1,mk(3,1));
      add(0,0,4'b1000,4'b1000,0,4'b1000,1,mk(3,2));
      add(0,0,4'b0000,4'b0000,1,4'b0000,0,64'd0);
      add(0,0,4'b0000,4'b0000,0,4'b0000,0,64'd0);
      // Owner valid gap while another requester waits
      add(1,0,4'b0101,4'b0100,0,4'b0000,0,64'd0);
      add(0,0,4'b0101,4'b0100,0,4'b0001,1,mk(0,0));
      for (int k = 0; k < 3; k++) add(0,0,4'b0100,4'b0100,0,4'b0001,0,64'd0);
      add(0,0,4'b0101,4'b0100,0,4'b0001,1,mk(0,1));
      add(0,0,4'b0101,4'b0101,0,4'b0001,1,mk(0,2));
      add(0,0,4'b0100,4'b0100,0,4'b0000,0,64'd0);
      add(0,0,4'b0100,4'b0100,0,4'b0100,1,mk(2,0));
      add(0,0,4'b0000,4'b0000,0,4'b0000,0,64'd0);
      // Last coinciding with the BURST limit, twice back to back
      add(0,1,4'b0010,4'b0000,0,4'b0000,0,64'd0);
      for (int k = 0; k < 3; k++) add(0,0,4'b0010,4'b0000,0,4'b0010,1,mk(1,k));
      add(0,0,4'b0010,4'b0010,0,4'b0010,1,mk(1,3));
      add(0,0,4'b0010,4'b0000,0,4'b0000,0,64'd0);
      for (int k = 4; k < 7; k++) add(0,0,4'b0010,4'b0000,0,4'b0010,1,mk(1,k));
      add(0,0,4'b0010,4'b0010,0,4'b0010,1,mk(1,7));
      add(0,0,4'b0000,4'b0000,0,4'b0000,0,64'd0);

      // Reset state while rst_n is held low
      repeat (2) @(negedge clk);
      check("rst_grant", 64'(grant), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_din", fifo_din, 64'd0);
      check("rst_stall", 64'(stall_cnt), 64'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      foreach (vecs[k]) apply(vecs[k]);

      // Asynchronous reset after 2 of 4 words
      vecs.delete();
      add(0,1,4'b0010,4'b0000,0,4'b0000,0,64'd0);
      add(0,0,4'b0010,4'b0000,0,4'b0010,1,mk(1,0));
      add(0,0,4'b0010,4'b0000,0,4'b0010,1,mk(1,1));
      foreach (vecs[k]) apply(vecs[k]);
      step_edge();
      drive(4'b0010, 4'b0000, 1'b0);
      #1;
      check("pre_rst_wr_en", 64'(fifo_wr_en), 64'd1);
      rst_n = 1'b0;
      req_valid = 4'b0000;
      #1;
      check("async_grant", 64'(grant), 64'd0);
      check("async_busy", 64'(busy), 64'd0);
      check("async_wr_en", 64'(fifo_wr_en), 64'd0);
      check("async_ready", 64'(req_ready), 64'd0);
      check("async_din", fifo_din, 64'd0);
      #1 rst_n = 1'b1;
      hs = '0;
      clear_seq();
      stall_model = '0;

      vecs.delete();
      add(0,0,4'b0011,4'b0011,0,4'b0000,0,64'd0);
      add(0,0,4'b0011,4'b0011,0,4'b0001,1,mk(0,0));
      add(0,0,4'b0010,4'b0010,0,4'b0000,0,64'd0);
      add(0,0,4'b0010,4'b0010,0,4'b0010,1,mk(1,0));
      add(0,0,4'b0000,4'b0000,0,4'b0000,0,64'd0);
      foreach (vecs[k]) apply(vecs[k]);

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
